edge_event_arbiter: RTL and testbench

//  Multi-channel edge-event scheduler. Per-channel rise/fall detection
//  (registered-delay compare) on NUM_CH synchronous inputs. Detected edges are

---
 rtl/edge_event_arbiter.sv | 140 ++++++++++++++
 tb/tb_edge_event_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter: per-channel edge detect, one-deep pending slot per
// channel, round-robin share of a single valid/ready event port.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_event_arbiter #(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] d_in,
  input  logic [NUM_CH-1:0] rise_en,
  input  logic [NUM_CH-1:0] fall_en,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic              evt_is_rise,
  output logic [NUM_CH-1:0] overflow,
  input  logic              ovf_clr
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state;
  logic [NUM_CH-1:0] d_dly;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_rise;
  logic [CH_W-1:0]   rr_ptr;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_ch;
  logic              grant;
  logic [NUM_CH-1:0] gnt_onehot;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] pend_rise_nxt;
  logic [NUM_CH-1:0] ovf_set;
  logic [CH_W-1:0]   rr_nxt;

  assign rise = d_in & ~d_dly & rise_en;
  assign fall = ~d_in & d_dly & fall_en;

  // Round-robin search: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(off);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      idx = sum[CH_W-1:0];
      if (!gnt_found && pend[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end
  end

  assign grant      = gnt_found && ((state == IDLE) || evt_ready);
  assign gnt_onehot = grant ? (NUM_CH'(1) << gnt_ch) : '0;
  assign rr_nxt     = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;

  // A slot granted this cycle is free to take a new edge in the same cycle.
  always_comb begin
    pend_nxt      = pend & ~gnt_onehot;
    pend_rise_nxt = pend_rise;
    ovf_set       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i] || fall[i]) begin
        if (!pend[i] || gnt_onehot[i]) begin
          pend_nxt[i]      = 1'b1;
          pend_rise_nxt[i] = rise[i];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_dly     <= '0;
      pend      <= '0;
      pend_rise <= '0;
      overflow  <= '0;
    end else begin
      d_dly     <= d_in;
      pend      <= pend_nxt;
      pend_rise <= pend_rise_nxt;
      overflow  <= (ovf_clr ? '0 : overflow) | ovf_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      evt_valid   <= 1'b0;
      evt_ch      <= '0;
      evt_is_rise <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            evt_valid   <= 1'b1;
            evt_ch      <= gnt_ch;
            evt_is_rise <= pend_rise[gnt_ch];
            rr_ptr      <= rr_nxt;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (grant) begin
            evt_ch      <= gnt_ch;
            evt_is_rise <= pend_rise[gnt_ch];
            rr_ptr      <= rr_nxt;
          end else if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter: directed table, corner sequences and random stimulus
// against an event-level reference model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d_in, rise_en, fall_en, overflow;
  logic       evt_valid, evt_ready, evt_is_rise, ovf_clr;
  logic [1:0] evt_ch;

  int total = 0;
  int bad   = 0;

  edge_event_arbiter #(.NUM_CH(4)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .rise_en(rise_en), .fall_en(fall_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_is_rise(evt_is_rise), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: pending slots, pointer, presented event, sticky overflow.
  bit       m_pend[4];
  bit       m_prise[4];
  bit       m_valid, m_rise;
  int       m_ch, m_ptr;
  bit [3:0] m_ovf, m_dprev;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i]  = 1'b0;
      m_prise[i] = 1'b0;
    end
    m_valid = 0; m_rise = 0; m_ch = 0; m_ptr = 0; m_ovf = '0; m_dprev = '0;
  endtask

  task automatic model_step(input logic [3:0] d, re, fe, input logic rdy, clr);
    int g;
    bit np[4];
    bit nr[4];
    bit r, f;
    g = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < 4; k++) begin
        int c = (m_ptr + k) % 4;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (clr) m_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      r = d[i] && !m_dprev[i] && re[i];
      f = !d[i] && m_dprev[i] && fe[i];
      np[i] = m_pend[i] && (g != i);
      nr[i] = m_prise[i];
      if (r || f) begin
        if (!m_pend[i] || g == i) begin
          np[i] = 1'b1;
          nr[i] = r;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    if (g >= 0) begin
      m_valid = 1; m_ch = g; m_rise = m_prise[g]; m_ptr = (g + 1) % 4;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_pend = np; m_prise = nr; m_dprev = d;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, advance model, compare after the posedge.
  task automatic tick(input logic [3:0] d, re, fe, input logic rdy, clr);
    d_in = d; rise_en = re; fall_en = fe; evt_ready = rdy; ovf_clr = clr;
    model_step(d, re, fe, rdy, clr);
    @(negedge clk);
    chk("mdl_valid", int'(evt_valid), int'(m_valid));
    chk("mdl_ovf", int'(overflow), int'(m_ovf));
    if (m_valid) begin
      chk("mdl_ch", int'(evt_ch), m_ch);
      chk("mdl_rise", int'(evt_is_rise), int'(m_rise));
    end
  endtask

  typedef struct {
    logic [3:0] d, re, fe;
    logic       rdy, clr;
    logic       ev;
    logic [1:0] ch;
    logic       rs;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] d, re, fe, input logic rdy, clr, ev,
                     input logic [1:0] ch, input logic rs, input logic [3:0] ovf);
    vec_t v;
    v.d = d; v.re = re; v.fe = fe; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ch = ch; v.rs = rs; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int       nev;
    bit [3:0] seen;
    logic [3:0] rd, re_r, fe_r;

    // Rise/fall pulse on ch2, rise-disabled ch0, held ch1 with overflow on ch3,
    // reload of ch1 in its own grant cycle.
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0100, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0100, 4'hF, 4'hF, 1, 0, 1, 2, 1, 4'h0);
    add(4'b0100, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 1, 2, 0, 4'h0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0001, 4'hE, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0001, 4'hE, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0000, 4'hE, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0000, 4'hE, 4'hF, 1, 0, 1, 0, 0, 4'h0);
    add(4'b0000, 4'hE, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b0010, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h0);
    add(4'b0010, 4'hF, 4'hF, 0, 0, 1, 1, 1, 4'h0);
    add(4'b1010, 4'hF, 4'hF, 0, 0, 1, 1, 1, 4'h0);
    add(4'b0010, 4'hF, 4'hF, 0, 0, 1, 1, 1, 4'h8);
    add(4'b1010, 4'hF, 4'hF, 0, 0, 1, 1, 1, 4'h8);
    add(4'b1010, 4'hF, 4'hF, 0, 1, 1, 1, 1, 4'h0);
    add(4'b1010, 4'hF, 4'hF, 1, 0, 1, 3, 1, 4'h0);
    add(4'b1010, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b1000, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);
    add(4'b1010, 4'hF, 4'hF, 1, 0, 1, 1, 0, 4'h0);
    add(4'b1010, 4'hF, 4'hF, 1, 0, 1, 1, 1, 4'h0);
    add(4'b1010, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0);

    reset = 1'b1; d_in = '0; rise_en = 4'hF; fall_en = 4'hF;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch", int'(evt_ch), 0);
    chk("rst_rise", int'(evt_is_rise), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;

    // Simultaneous burst: ch0..3 back-to-back, next burst restarts at ch0.
    tick(4'b0000, 4'hF, 4'hF, 1, 0);
    tick(4'b1111, 4'hF, 4'hF, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick(4'b1111, 4'hF, 4'hF, 1, 0);
      chk("burst_r_valid", int'(evt_valid), 1);
      chk("burst_r_ch", int'(evt_ch), k);
      chk("burst_r_rise", int'(evt_is_rise), 1);
    end
    tick(4'b1111, 4'hF, 4'hF, 1, 0);
    chk("burst_r_end", int'(evt_valid), 0);
    tick(4'b0000, 4'hF, 4'hF, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick(4'b0000, 4'hF, 4'hF, 1, 0);
      chk("burst_f_valid", int'(evt_valid), 1);
      chk("burst_f_ch", int'(evt_ch), k);
      chk("burst_f_rise", int'(evt_is_rise), 0);
    end
    tick(4'b0000, 4'hF, 4'hF, 1, 0);
    chk("burst_f_end", int'(evt_valid), 0);

    foreach (tbl[i]) begin
      tick(tbl[i].d, tbl[i].re, tbl[i].fe, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_ch", i), int'(evt_ch), int'(tbl[i].ch));
        chk($sformatf("tbl%0d_rise", i), int'(evt_is_rise), int'(tbl[i].rs));
      end
    end

    // Asynchronous reset with one event presented and three pending.
    repeat (4) tick(4'b0000, 4'hF, 4'hF, 1, 0);
    tick(4'b1111, 4'hF, 4'hF, 0, 0);
    tick(4'b1111, 4'hF, 4'hF, 0, 0);
    chk("ar_pre_valid", int'(evt_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", int'(evt_valid), 0);
    chk("ar_ch", int'(evt_ch), 0);
    chk("ar_rise", int'(evt_is_rise), 0);
    chk("ar_ovf", int'(overflow), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("ar_hold_valid", int'(evt_valid), 0);
    reset = 1'b0;
    nev = 0; seen = '0;
    repeat (7) begin
      tick(4'b1111, 4'hF, 4'hF, 1, 0);
      if (evt_valid) begin
        nev++;
        seen[evt_ch] = 1'b1;
        chk("ar_post_rise", int'(evt_is_rise), 1);
      end
    end
    chk("ar_post_count", nev, 4);
    chk("ar_post_seen", int'(seen), 15);

    // Random traffic against the reference model.
    rd = 4'b1111; re_r = 4'hF; fe_r = 4'hF;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) rd = rd ^ 4'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        re_r = 4'($urandom);
        fe_r = 4'($urandom);
      end
      tick(rd, re_r, fe_r, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
